instr_feeder: RTL

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder_pkg.sv | 16 +
 rtl/instr_feeder_prog_mem.sv | 24 ++
 rtl/instr_feeder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/instr_feeder_pkg.sv
// Shared types and default sizing for the instruction feeder.
package instr_feeder_pkg;

  localparam int DEFAULT_DEPTH   = 16;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_LO,
    WAIT_HI,
    FIN
  } state_e;

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program store for the instruction feeder: one synchronous write port and
// one combinational read port.
module prog_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [15:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [15:0]              rdata
);

  logic [15:0] mem [DEPTH];

  // NOTE: the storage array has no reset; a program must survive a reset of
  // the sequencer, and clearing an array would also block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: issues a stored program to a CPU one word at a time
// (load, start, wait for completion) with a watchdog on each wait.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [15:0]              prog_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     run,
  output logic [15:0]              instr,
  output logic                     load,
  output logic                     start,
  input  logic                     waiting,
  input  logic [15:0]              cpu_out,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic [15:0]              last_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  state_e        state, state_nxt;
  logic [AW:0]   len_q, issued;
  logic [WW-1:0] wdog;
  logic [15:0]   mem_rdata;
  logic          mem_we, wdog_expired, last_instr;

  // Programming is only possible while no run is in flight.
  assign mem_we = prog_we && (state == IDLE);

  prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  assign wdog_expired = (wdog == WDOG_LAST);
  assign last_instr   = ((issued + (AW+1)'(1)) == len_q);
  assign busy         = (state != IDLE);
  assign instr        = (state == LOAD || state == START) ? mem_rdata : '0;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE:    if (run) state_nxt = (len == '0) ? FIN : LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = START;
      end
      START: begin
        start     = 1'b1;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!waiting)          state_nxt = WAIT_HI;
        else if (wdog_expired) state_nxt = IDLE;
      end
      WAIT_HI: begin
        if (waiting)           state_nxt = last_instr ? FIN : LOAD;
        else if (wdog_expired) state_nxt = IDLE;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      issued      <= '0;
      wdog        <= '0;
      pc          <= '0;
      last_out    <= '0;
      timeout_err <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIN);
      case (state)
        IDLE: begin
          if (run) begin
            len_q       <= len;
            issued      <= '0;
            pc          <= '0;
            timeout_err <= 1'b0;
          end
        end
        START: wdog <= '0;
        WAIT_LO: begin
          if (!waiting)          wdog        <= '0;
          else if (wdog_expired) timeout_err <= 1'b1;
          else                   wdog        <= wdog + WW'(1);
        end
        WAIT_HI: begin
          if (waiting) begin
            last_out <= cpu_out;
            pc       <= pc + AW'(1);
            issued   <= issued + (AW+1)'(1);
          end else if (wdog_expired) begin
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
